// File: rtl/mem_access_unit_if.sv
// Bundle of the control-path request/response handshake and the data-memory bus.
// slave  : the load/store unit side (takes requests, drives memory).
// master : the requester plus memory side (drives requests, returns read data).
// Signals:
//   req_valid/req_ready/req_op/req_base/req_imm/req_wdata  request handshake and payload
//   resp_valid/resp_rdata/resp_fault                       one-cycle response
//   sp_out                                                 current stack pointer
//   MemR/MemW/mem_addr/mem_wdata/mem_rdata                 data-memory bus
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [31:0]       req_base;
    logic [31:0]       req_imm;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_fault;
    logic [ADDR_W-1:0] sp_out;
    logic              MemR;
    logic              MemW;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_op, req_base, req_imm, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault, sp_out,
               MemR, MemW, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_op, req_base, req_imm, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault, sp_out,
               MemR, MemW, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit for the multicycle datapath. Accepts one LD/ST/PUSH/POP at a
// time, computes the word address, owns the stack pointer, drives the data
// memory and returns a single response per request. Address and stack faults
// are answered without any memory access.
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   mem_access_unit_if.slave (request/response handshake + memory bus)
module mem_access_unit #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned SP_INIT = 1023
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_unit_if.slave bus
);

    localparam logic [ADDR_W-1:0] SpInit  = ADDR_W'(SP_INIT);
    localparam logic [2:0]        LatLast = 3'(MEM_LAT);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OpLd   = 2'b00,
        OpSt   = 2'b01,
        OpPush = 2'b10,
        OpPop  = 2'b11
    } op_e;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fault_q, fault_d;

    logic [31:0]       ea;
    logic [ADDR_W-1:0] req_addr;
    logic              req_fault;
    logic              op_is_write;

    // Address and fault for the request currently offered on the bus.
    always_comb begin
        ea        = bus.req_base + bus.req_imm;
        req_addr  = ea[ADDR_W-1:0];
        req_fault = (ea >> ADDR_W) != 32'd0;
        case (op_e'(bus.req_op))
            OpPush: begin
                // Pre-decrement: the new top lives one below the current sp.
                req_addr  = sp_q - ADDR_W'(1);
                req_fault = (sp_q == '0);
            end
            OpPop: begin
                req_addr  = sp_q;
                req_fault = (sp_q == SpInit);
            end
            default: ;
        endcase
    end

    assign op_is_write = (op_q == OpSt) || (op_q == OpPush);

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        cnt_d          = cnt_q;
        sp_d           = sp_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        fault_d        = fault_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.MemR       = 1'b0;
        bus.MemW       = 1'b0;

        case (state_q)
            StIdle: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    op_d    = op_e'(bus.req_op);
                    rdata_d = '0;
                    fault_d = req_fault;
                    cnt_d   = '0;
                    if (req_fault) begin
                        // Memory bus keeps its previous address/data on a fault.
                        state_d = StDone;
                    end else begin
                        state_d = StAccess;
                        addr_d  = req_addr;
                        wdata_d = bus.req_wdata;
                    end
                end
            end
            StAccess: begin
                if (op_is_write) begin
                    bus.MemW = 1'b1;
                    state_d  = StDone;
                    if (op_q == OpPush) begin
                        sp_d = sp_q - ADDR_W'(1);
                    end
                end else begin
                    bus.MemR = 1'b1;
                    if (cnt_q == LatLast) begin
                        rdata_d = bus.mem_rdata;
                        state_d = StDone;
                        if (op_q == OpPop) begin
                            sp_d = sp_q + ADDR_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            StDone: begin
                bus.resp_valid = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = fault_q;
    assign bus.sp_out     = sp_q;
    assign bus.mem_addr   = 32'(addr_q);
    assign bus.mem_wdata  = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OpLd;
            cnt_q   <= '0;
            sp_q    <= SpInit;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            sp_q    <= sp_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface: a load/store unit for the multicycle datapath.
- Accepts one LD/ST/PUSH/POP request at a time from the control path over a valid/ready handshake.
- Computes the word address, owns the stack pointer, and drives MemR/MemW/address/writeData toward data memory.
- Captures read data and returns one response per request, flagging address and stack faults without touching memory.

Parameters:
- ADDR_W, 10: word-index width of data memory (1024 words); the effective address must fit in ADDR_W bits.
- MEM_LAT, 1: extra cycles MemR is held before read data is sampled (0..7).
- SP_INIT, 1023: reset and empty-stack value of the stack pointer.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  2  00=LD, 01=ST, 10=PUSH, 11=POP.
- req_base  in  32  base register value (LD/ST).
- req_imm  in  32  sign-extended offset (LD/ST).
- req_wdata  in  32  store/push data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  loaded/popped word (0 for ST/PUSH/fault).
- resp_fault  out  1  request rejected; valid with resp_valid.
- sp_out  out  ADDR_W  current stack pointer.
- MemR  out  1  memory read enable.
- MemW  out  1  memory write enable.
- mem_addr  out  32  word address; upper 32-ADDR_W bits always 0.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data from memory.

Behaviour:
- Reset state (async, immediate on rst_n low): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, MemR=0, MemW=0, mem_addr=0, mem_wdata=0, sp=SP_INIT.
- Reset mid-operation aborts the operation: no response is produced, sp returns to SP_INIT, and any in-flight write is dropped.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: req_ready=1. On req_valid at an edge, latch op and wdata, compute the address, run the fault check, then:
  - fault: go to DONE;
  - otherwise: go to ACCESS.
- Effective address:
  - LD/ST: ea = req_base + req_imm (32-bit wrap). Fault if ea[31:ADDR_W] != 0.
  - PUSH: address = sp-1 (pre-decrement). Fault if sp==0 (overflow).
  - POP: address = sp (post-increment). Fault if sp==SP_INIT (underflow).
- ACCESS: mem_addr and mem_wdata are registered and stable for the whole state; exactly one of MemR/MemW is high.
  - ST/PUSH: MemW high for exactly 1 cycle, then DONE.
  - LD/POP: MemR high for MEM_LAT+1 cycles; mem_rdata is captured into resp_rdata on the last ACCESS cycle; then DONE.
- DONE: resp_valid=1 for exactly one cycle, req_ready=0, then IDLE.
- sp update (SP is never modified on a fault):
  - PUSH: sp <= sp-1 on the edge leaving ACCESS.
  - POP: sp <= sp+1 on the edge leaving ACCESS.
- Outside ACCESS: MemR=MemW=0; mem_addr/mem_wdata hold their last values. MemR and MemW are never both high.
- Latency from accepting edge to resp_valid high:
  - ST/PUSH: 2 cycles.
  - LD/POP: 2+MEM_LAT cycles.
  - fault: 1 cycle.
- Throughput: one request per (latency+1) cycles. req_valid while req_ready=0 is ignored; the requester must hold it.
- Fault response: resp_fault=1, resp_rdata=0. For ST/PUSH, resp_rdata=0 and resp_fault=0.
- Request inputs are sampled only at the accepting edge; later changes have no effect.

Test Plan:
- Reset with MEM_LAT=1: ST base=5 imm=3 wdata=0xDEADBEEF -> MemW high 1 cycle at mem_addr=8, resp_valid 2 cycles after accept, fault=0. Then LD base=10 imm=-2 -> MemR high 2 cycles at addr 8, resp_rdata=0xDEADBEEF 3 cycles after accept.
- Stack: PUSH 0x11, PUSH 0x22 -> writes to 1022 then 1021, sp_out=1021. POP -> rdata 0x22, sp=1022. POP -> rdata 0x11, sp=1023.
- POP at sp=1023 -> resp_fault=1 one cycle after accept, no MemR, sp unchanged.
- Force sp=0 via 1023 PUSHes, then PUSH -> fault, no MemW. LD base=0x400 imm=0 -> fault, rdata=0.
- Assert rst_n low during a LD ACCESS cycle -> MemR drops immediately, no resp_valid, req_ready=1 and sp_out=1023 after release. Back-to-back req_valid held high -> second request accepted only in IDLE.
- Sweep MEM_LAT 0..3 -> MemR width = MEM_LAT+1 and load latency = 2+MEM_LAT cycles.
